// File: rtl/image_line_packer_if.sv
`default_nettype none
// ============================================================================
// image_line_packer_if : pixel-stream valid/ready bundle into the line packer
// Revision: 1.0
// ============================================================================
interface image_line_packer_if #(
    parameter int PIX_W = 32
);
    logic             pix_valid;
    logic             pix_ready;
    logic [PIX_W-1:0] pix_data;
    logic             pix_sof;

    modport master (output pix_valid, output pix_data, output pix_sof, input  pix_ready);
    modport slave  (input  pix_valid, input  pix_data, input  pix_sof, output pix_ready);
endinterface
`default_nettype wire

// File: rtl/image_line_packer.sv
`default_nettype none
// ============================================================================
// image_line_packer : packs a 7x7 pixel stream into seven line registers and
// pulses de_out per frame. Optional SOF checking: IMAGE_LINE_PACKER_SOF_CHECK_EN.
// Revision: 1.0
// ============================================================================
module image_line_packer #(
    parameter int PIX_W   = 32,
    parameter int MIN_GAP = 4,
    parameter int CNT_W   = 16
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    image_line_packer_if.slave        pix,
    output logic [7*PIX_W-1:0]        line_0_out,
    output logic [7*PIX_W-1:0]        line_1_out,
    output logic [7*PIX_W-1:0]        line_2_out,
    output logic [7*PIX_W-1:0]        line_3_out,
    output logic [7*PIX_W-1:0]        line_4_out,
    output logic [7*PIX_W-1:0]        line_5_out,
    output logic [7*PIX_W-1:0]        line_6_out,
    output logic                      de_out,
    output logic [CNT_W-1:0]          frames_out,
    output logic                      sof_err
);
    localparam int LINE_W = 7 * PIX_W;
    localparam int GAP_W  = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_FULL    = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_ready;
    logic [5:0]         r_pix_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [PIX_W-1:0]   r_shadow [0:48];
    logic [LINE_W-1:0]  r_line   [0:6];
    logic               r_de;
    logic [CNT_W-1:0]   r_frames;

    logic               w_accept;
    logic               w_store;
    logic               w_transfer;
    logic               w_sof_err_set;
    logic [5:0]         w_wr_idx;
    logic [5:0]         w_cnt_next;

    always_comb begin
        w_next_state  = r_state;
        w_transfer    = 1'b0;
        w_accept      = pix.pix_valid && r_ready;
        w_store       = w_accept;
        w_wr_idx      = r_pix_cnt;
        w_cnt_next    = r_pix_cnt;
        w_sof_err_set = 1'b0;
`ifdef IMAGE_LINE_PACKER_SOF_CHECK_EN
        // A misplaced SOF restarts the frame at slot 0; a missing SOF drops the pixel.
        if (w_accept && pix.pix_sof && (r_pix_cnt != 6'd0)) begin
            w_wr_idx      = 6'd0;
            w_sof_err_set = 1'b1;
        end else if (w_accept && !pix.pix_sof && (r_pix_cnt == 6'd0)) begin
            w_store       = 1'b0;
            w_sof_err_set = 1'b1;
        end
`endif
        if (w_store) begin
            w_cnt_next = (w_wr_idx == 6'd48) ? 6'd0 : w_wr_idx + 6'd1;
        end
        if (r_state == S_COLLECT) begin
            if (w_store && (w_wr_idx == 6'd48)) begin
                w_next_state = S_FULL;
            end
        end else begin
            if (r_gap_cnt == '0) begin
                w_transfer   = 1'b1;
                w_next_state = S_COLLECT;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_COLLECT;
            r_ready   <= 1'b0;
            r_pix_cnt <= 6'd0;
            r_gap_cnt <= '0;
            r_de      <= 1'b0;
            r_frames  <= '0;
            for (int r = 0; r < 7; r++) begin
                r_line[r] <= '0;
            end
        end else begin
            r_state   <= w_next_state;
            r_ready   <= (w_next_state == S_COLLECT);
            r_pix_cnt <= w_cnt_next;
            r_de      <= w_transfer;
            if (r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end
            if (w_transfer) begin
                r_gap_cnt <= GAP_W'(MIN_GAP - 1);
                r_frames  <= r_frames + 1'b1;
                for (int r = 0; r < 7; r++) begin
                    for (int c = 0; c < 7; c++) begin
                        r_line[r][(7-c)*PIX_W-1 -: PIX_W] <= r_shadow[r*7+c];
                    end
                end
            end
        end
    end

    // Every slot is rewritten before the next transfer, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_shadow[w_wr_idx] <= pix.pix_data;
        end
    end

`ifdef IMAGE_LINE_PACKER_SOF_CHECK_EN
    logic r_sof_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sof_err <= 1'b0;
        end else if (w_sof_err_set) begin
            r_sof_err <= 1'b1;
        end
    end

    assign sof_err = r_sof_err;
`else
    logic w_unused_sof;

    assign w_unused_sof = pix.pix_sof ^ w_sof_err_set;
    assign sof_err      = 1'b0;
`endif

    assign pix.pix_ready = r_ready;
    assign de_out        = r_de;
    assign frames_out    = r_frames;
    assign line_0_out    = r_line[0];
    assign line_1_out    = r_line[1];
    assign line_2_out    = r_line[2];
    assign line_3_out    = r_line[3];
    assign line_4_out    = r_line[4];
    assign line_5_out    = r_line[5];
    assign line_6_out    = r_line[6];
endmodule
`default_nettype wire

// File: tb/tb_image_line_packer.sv
`default_nettype none
// ============================================================================
// tb_image_line_packer : random-stimulus bench with a frame-level reference
// model; DUT A uses MIN_GAP=4, DUT B uses MIN_GAP=80.
// Revision: 1.0
// ============================================================================
module tb_image_line_packer;
    localparam int PIX_W = 32;
    localparam int LW    = 7 * PIX_W;
    localparam int GAP_A = 4;
    localparam int GAP_B = 80;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    image_line_packer_if #(.PIX_W(PIX_W)) ifa ();
    image_line_packer_if #(.PIX_W(PIX_W)) ifb ();

    logic [LW-1:0] la [7];
    logic [LW-1:0] lb [7];
    logic          de_a, de_b, se_a, se_b;
    logic [15:0]   fr_a, fr_b;

    image_line_packer #(.PIX_W(PIX_W), .MIN_GAP(GAP_A), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .pix(ifa),
        .line_0_out(la[0]), .line_1_out(la[1]), .line_2_out(la[2]), .line_3_out(la[3]),
        .line_4_out(la[4]), .line_5_out(la[5]), .line_6_out(la[6]),
        .de_out(de_a), .frames_out(fr_a), .sof_err(se_a)
    );

    image_line_packer #(.PIX_W(PIX_W), .MIN_GAP(GAP_B), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .pix(ifb),
        .line_0_out(lb[0]), .line_1_out(lb[1]), .line_2_out(lb[2]), .line_3_out(lb[3]),
        .line_4_out(lb[4]), .line_5_out(lb[5]), .line_6_out(lb[6]),
        .de_out(de_b), .frames_out(fr_b), .sof_err(se_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: frames as plain pixel arrays, pulse times by edge arithmetic.
    logic [31:0]   m_cur    [2][49];
    logic [31:0]   m_pf     [2][49];
    logic [LW-1:0] m_line   [2][7];
    int            m_cnt    [2];
    int            m_frames [2];
    bit            m_pend   [2];
    bit            m_de     [2];
    bit            m_rdy    [2];
    bit            m_serr   [2];
    longint        m_last   [2];
    int            m_gap    [2] = '{GAP_A, GAP_B};
    int            lowcnt   [2] = '{0, 0};
    longint        pt_a [$];
    longint        pt_b [$];
    longint        cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : model
        logic          v   [2];
        logic          s   [2];
        logic          r   [2];
        logic          od  [2];
        logic          ose [2];
        logic [31:0]   dd  [2];
        logic [15:0]   ofr [2];
        logic [LW-1:0] ol  [2][7];
        bit            acc;
        bit            keep;
        string         nm;
        v[0] = ifa.pix_valid; s[0] = ifa.pix_sof; r[0] = ifa.pix_ready; dd[0] = ifa.pix_data;
        v[1] = ifb.pix_valid; s[1] = ifb.pix_sof; r[1] = ifb.pix_ready; dd[1] = ifb.pix_data;
        od[0] = de_a; od[1] = de_b; ose[0] = se_a; ose[1] = se_b; ofr[0] = fr_a; ofr[1] = fr_b;
        for (int i = 0; i < 7; i++) begin
            ol[0][i] = la[i];
            ol[1][i] = lb[i];
        end
        for (int d = 0; d < 2; d++) begin
            nm = (d == 0) ? "A" : "B";
            if (reset) begin
                for (int i = 0; i < 7; i++) m_line[d][i] = '0;
                m_cnt[d] = 0; m_frames[d] = 0; m_pend[d] = 0; m_de[d] = 0;
                m_rdy[d] = 0; m_serr[d] = 0; m_last[d] = -1000;
            end
            for (int i = 0; i < 7; i++) chk({nm, "_line"}, ol[d][i], m_line[d][i]);
            chk({nm, "_de_out"},     LW'(od[d]),  LW'(m_de[d]));
            chk({nm, "_frames_out"}, LW'(ofr[d]), LW'(m_frames[d]));
            chk({nm, "_pix_ready"},  LW'(r[d]),   LW'(m_rdy[d]));
            chk({nm, "_sof_err"},    LW'(ose[d]), LW'(m_serr[d]));
            if (od[d]) begin
                if (d == 0) pt_a.push_back(cyc);
                else        pt_b.push_back(cyc);
            end
            if (!r[d] && !reset) lowcnt[d]++;
            if (!reset) begin
                m_de[d] = 0;
                acc = v[d] && m_rdy[d];
                if (m_pend[d] && (cyc + 1 >= m_last[d] + m_gap[d])) begin
                    for (int k = 0; k < 49; k++)
                        m_line[d][k/7][(7-k%7)*32-1 -: 32] = m_pf[d][k];
                    m_frames[d] = (m_frames[d] + 1) % 65536;
                    m_de[d]     = 1;
                    m_last[d]   = cyc + 1;
                    m_pend[d]   = 0;
                end else if (acc) begin
                    keep = 1;
`ifdef IMAGE_LINE_PACKER_SOF_CHECK_EN
                    if (s[d] && m_cnt[d] != 0) begin
                        m_serr[d] = 1;
                        m_cnt[d]  = 0;
                    end else if (!s[d] && m_cnt[d] == 0) begin
                        m_serr[d] = 1;
                        keep      = 0;
                    end
`endif
                    if (keep) begin
                        m_cur[d][m_cnt[d]] = dd[d];
                        m_cnt[d]++;
                        if (m_cnt[d] == 49) begin
                            for (int k = 0; k < 49; k++) m_pf[d][k] = m_cur[d][k];
                            m_pend[d] = 1;
                            m_cnt[d]  = 0;
                        end
                    end
                end
                m_rdy[d] = !m_pend[d];
            end
        end
    end

    task automatic set_in(input int d, input bit v, input logic [31:0] x, input bit s);
        if (d == 0) begin
            ifa.pix_valid = v; ifa.pix_data = x; ifa.pix_sof = s;
        end else begin
            ifb.pix_valid = v; ifb.pix_data = x; ifb.pix_sof = s;
        end
    endtask

    function automatic bit sofv(input int k);
`ifdef IMAGE_LINE_PACKER_SOF_CHECK_EN
        return (k == 0);
`else
        return 1'($urandom_range(1));
`endif
    endfunction

    task automatic push(input int d, input logic [31:0] x, input bit s, input int idle_pct);
        bit r;
        while ($urandom_range(99) < idle_pct) begin
            set_in(d, 1'b0, $urandom, 1'($urandom_range(1)));
            @(posedge clk); #1;
        end
        set_in(d, 1'b1, x, s);
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            r = (d == 0) ? ifa.pix_ready : ifb.pix_ready;
            @(posedge clk); #1;
            if (r) return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL push_timeout: dut %0d got no accept, required accept within 1000 cycles", d);
    endtask

    task automatic send_frame(input int d, input bit ramp, input int idle_pct);
        for (int k = 0; k < 49; k++)
            push(d, ramp ? 32'(32'h3F800000 + k) : $urandom, sofv(k), idle_pct);
    endtask

    task automatic idle(input int d, input int n);
        set_in(d, 1'b0, 32'h0, 1'b0);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int lc;
        set_in(0, 1'b0, 32'h0, 1'b0);
        set_in(1, 1'b0, 32'h0, 1'b0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",  LW'(ifa.pix_ready), LW'(0));
        chk("rst_line0",  la[0], '0);
        chk("rst_frames", LW'(fr_a), LW'(0));
        chk("rst_de",     LW'(de_a), LW'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        // ramp frame with known literal values
        send_frame(0, 1'b1, 0);
        idle(0, 10);
        chk("ramp_l0_c0", LW'(la[0][223:192]), LW'(32'h3F800000));
        chk("ramp_l3_c3", LW'(la[3][127:96]),  LW'(32'h3F800018));
        chk("ramp_l6_c6", LW'(la[6][31:0]),    LW'(32'h3F800030));
        chk("ramp_frames", LW'(fr_a), LW'(1));

        // two back-to-back frames
        pt_a.delete();
        lc = lowcnt[0];
        send_frame(0, 1'b0, 0);
        send_frame(0, 1'b0, 0);
        idle(0, 10);
        chk("b2b_pulses", LW'(pt_a.size()), LW'(2));
        if (pt_a.size() == 2) chk("b2b_spacing", LW'(pt_a[1] - pt_a[0]), LW'(50));
        chk("b2b_ready_low", LW'(lowcnt[0] - lc), LW'(2));
        chk("b2b_frames", LW'(fr_a), LW'(3));

        // random idle gaps
        for (int f = 0; f < 3; f++) send_frame(0, 1'b0, 30);
        idle(0, 10);
        chk("gaps_frames", LW'(fr_a), LW'(6));

        // reset mid-frame
        for (int k = 0; k < 20; k++) push(0, $urandom, sofv(k), 0);
        set_in(0, 1'b0, 32'h0, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_rst_line0",  la[0], '0);
        chk("mid_rst_line6",  la[6], '0);
        chk("mid_rst_frames", LW'(fr_a), LW'(0));
        pt_a.delete();
        send_frame(0, 1'b0, 0);
        idle(0, 10);
        chk("post_rst_pulses", LW'(pt_a.size()), LW'(1));
        chk("post_rst_frames", LW'(fr_a), LW'(1));

        // long minimum gap on DUT B
        pt_b.delete();
        send_frame(1, 1'b0, 0);
        send_frame(1, 1'b0, 0);
        idle(1, 100);
        chk("gap80_pulses", LW'(pt_b.size()), LW'(2));
        if (pt_b.size() == 2) chk("gap80_spacing", LW'(pt_b[1] - pt_b[0]), LW'(80));
        chk("gap80_frames", LW'(fr_b), LW'(2));

`ifdef IMAGE_LINE_PACKER_SOF_CHECK_EN
        pt_a.delete();
        for (int k = 0; k < 10; k++) push(0, $urandom, (k == 0), 0);
        send_frame(0, 1'b0, 0);
        idle(0, 10);
        chk("sof_err_set", LW'(se_a), LW'(1));
        chk("sof_pulses",  LW'(pt_a.size()), LW'(1));
        chk("sof_frames",  LW'(fr_a), LW'(2));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
